// File: rtl/two_of_five_pkg.sv
// Shared definitions for the two-out-of-five word assembler: code patterns,
// error nibble, FSM state type and the pattern-to-digit decode function.
package two_of_five_pkg;

   localparam logic [4:0] CODE_0 = 5'b11000;
   localparam logic [4:0] CODE_1 = 5'b00011;
   localparam logic [4:0] CODE_2 = 5'b00101;
   localparam logic [4:0] CODE_3 = 5'b00110;
   localparam logic [4:0] CODE_4 = 5'b01001;
   localparam logic [4:0] CODE_5 = 5'b01010;
   localparam logic [4:0] CODE_6 = 5'b01100;
   localparam logic [4:0] CODE_7 = 5'b10001;
   localparam logic [4:0] CODE_8 = 5'b10010;
   localparam logic [4:0] CODE_9 = 5'b10100;

   localparam logic [3:0] ERR_NIBBLE = 4'hF;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   // Returns {valid, digit}; anything outside the ten legal patterns is invalid.
   function automatic logic [4:0] decode_digit(input logic [4:0] code);
      logic [4:0] res;
      res = {1'b0, ERR_NIBBLE};
      case (code)
         CODE_0:  res = {1'b1, 4'd0};
         CODE_1:  res = {1'b1, 4'd1};
         CODE_2:  res = {1'b1, 4'd2};
         CODE_3:  res = {1'b1, 4'd3};
         CODE_4:  res = {1'b1, 4'd4};
         CODE_5:  res = {1'b1, 4'd5};
         CODE_6:  res = {1'b1, 4'd6};
         CODE_7:  res = {1'b1, 4'd7};
         CODE_8:  res = {1'b1, 4'd8};
         CODE_9:  res = {1'b1, 4'd9};
         default: res = {1'b0, ERR_NIBBLE};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/two_of_five_digit_decode.sv
// Combinational code-word decode; the checker's DET verdict overrides a legal pattern.
module two_of_five_digit_decode
   import two_of_five_pkg::*;
(
   input  logic [4:0] code_i,
   input  logic       det_i,
   output logic       dig_ok_o,
   output logic [3:0] digit_o
);

   logic [4:0] dec_s;

   assign dec_s    = decode_digit(code_i);
   assign dig_ok_o = dec_s[4] & ~det_i;
   assign digit_o  = dig_ok_o ? dec_s[3:0] : ERR_NIBBLE;

endmodule

// File: rtl/two_of_five_word_assembler.sv
// Packs DIGITS decoded two-out-of-five digits into one BCD word with a
// per-word error flag and a saturating invalid-word counter.
module two_of_five_word_assembler
   import two_of_five_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [4:0]            code_i,
   input  logic                  det_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [4*DIGITS-1:0]   bcd_word_o,
   output logic                  out_err_o,
   input  logic                  clr_err_i,
   output logic [7:0]            err_count_o
);

   localparam logic [2:0] IDX_LAST = 3'(DIGITS - 1);

   state_e                state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [4*DIGITS-1:0]   word_q, word_d;
   logic                  err_q, err_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  live_q;

   logic                  dig_ok_s;
   logic [3:0]            digit_s;
   logic                  accept_s;
   logic                  inv_s;
   logic [4*DIGITS+3:0]   word_ext_s;

   two_of_five_digit_decode u_decode (
      .code_i   (code_i),
      .det_i    (det_i),
      .dig_ok_o (dig_ok_s),
      .digit_o  (digit_s)
   );

   // live_q keeps IN_READY low until the first edge after reset release.
   assign in_ready_o  = live_q & (state_q == COLLECT);
   assign out_valid_o = (state_q == HOLD);
   assign bcd_word_o  = word_q;
   assign out_err_o   = err_q;
   assign err_count_o = cnt_q;

   assign accept_s   = in_valid_i & in_ready_o;
   assign inv_s      = accept_s & ~dig_ok_s;
   assign word_ext_s = {word_q, digit_s};

   // Next-state logic for the collect/hold FSM, shift register and counter.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      case (state_q)
         COLLECT: begin
            if (accept_s) begin
               word_d = word_ext_s[4*DIGITS-1:0];
               err_d  = err_q | ~dig_ok_s;
               if (idx_q == IDX_LAST) begin
                  state_d = HOLD;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               state_d = COLLECT;
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               state_d = COLLECT;
               idx_d   = 3'd0;
               err_d   = 1'b0;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = COLLECT;
            idx_d   = 3'd0;
            err_d   = 1'b0;
         end
      endcase

      // A clear that coincides with an invalid accept still counts that word.
      if (clr_err_i) begin
         cnt_d = inv_s ? 8'd1 : 8'd0;
      end else if (inv_s && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= COLLECT;
         idx_q   <= 3'd0;
         word_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         live_q  <= 1'b1;
      end
   end

endmodule

// File: doc/two_of_five_word_assembler.md
# two_of_five_word_assembler

Downstream consumer of the two-out-of-five code checker. Accepts 5-bit code words together with the checker's DET flag over a valid/ready handshake, and decodes each word to a BCD digit. Packs DIGITS consecutive digits into one output word, presented on a second valid/ready handshake. Flags words that contain an invalid digit and keeps a saturating count of invalid code words.

## Interface
- DIGITS, default 4: digits per output word; legal range 1..8.
- CLK  input  1: rising-edge clock.
- RST_N  input  1: asynchronous, active-low reset.
- IN_VALID  input  1: CODE/DET hold a code word.
- IN_READY  output  1: block accepts a code word this cycle.
- CODE  input  5: two-out-of-five code word. Weights for bits [4:0] are 7,4,2,1,0.
- DET  input  1: checker verdict; 0 = valid, 1 = error.
- OUT_VALID  output  1: BCD_WORD/OUT_ERR are valid.
- OUT_READY  input  1: consumer accepts the output word.
- BCD_WORD  output  4*DIGITS: packed digits; first accepted digit in the MS nibble.
- OUT_ERR  output  1: at least one digit of this word was invalid.
- CLR_ERR  input  1: synchronous clear of ERR_COUNT.
- ERR_COUNT  output  8: count of invalid code words, saturating.

## Operation
- Reset values: IN_READY=0 during reset, then 1 from the first edge after deassertion. OUT_VALID=0, BCD_WORD=0, OUT_ERR=0, ERR_COUNT=0. State is COLLECT and the digit index is 0.
- Digit decode uses weights 7-4-2-1-0:
  - 11000 → 0, 00011 → 1, 00101 → 2, 00110 → 3, 01001 → 4
  - 01010 → 5, 01100 → 6, 10001 → 7, 10010 → 8, 10100 → 9
- A code word is invalid if DET=1, or if CODE is not one of the ten legal patterns. The second check applies even when DET=0.
- An invalid digit is stored as nibble 4'hF, sets the per-word error flag, and increments ERR_COUNT.
- FSM states:
  - COLLECT: IN_READY=1, OUT_VALID=0. On accept (IN_VALID & IN_READY), shift the nibble into the word and increment the index. When the index reaches DIGITS-1 on an accept, go to HOLD.
  - HOLD: IN_READY=0, OUT_VALID=1. BCD_WORD and OUT_ERR hold stable. On OUT_READY, go to COLLECT; clear the index and error flag. BCD_WORD keeps its last value until it is overwritten.
- ERR_COUNT rules:
  - Increments by 1 per invalid accepted word and saturates at 255.
  - CLR_ERR alone sets it to 0.
  - CLR_ERR coinciding with an invalid accept sets it to 1.
- IN_VALID without IN_READY has no effect. CODE and DET are sampled only on an accept.

## Timing
- Accept-to-output latency: OUT_VALID rises on the clock edge that accepts the last digit. The word is visible from the following cycle.
- No bypass: in the cycle where OUT_VALID & OUT_READY complete, IN_READY is still 0. The first digit of the next word is accepted one cycle later at the earliest.
- Throughput: DIGITS+1 cycles per word at best.
- RST_N assertion at any point immediately forces all reset values and discards a partial or held word. There is no output glitch beyond the asynchronous clear.
- All outputs are registered except IN_READY, which is decoded from the state register.

## Structure
- Package two_of_five_pkg holds:
  - localparams for the ten code patterns
  - ERR_NIBBLE = 4'hF
  - state enum {COLLECT, HOLD}
  - a decode function returning {valid, digit[3:0]}
- Sub-module two_of_five_digit_decode: a combinational wrapper of the package function with inputs CODE and DET, and outputs DIG_OK and DIGIT[3:0]. It is instantiated once. The assembler holds the FSM, shift register, index and counter.

## Test plan
- DIGITS=4; feed 11000, 00011, 01010, 10100, all with DET=0, OUT_READY=1 → one word with BCD_WORD=16'h0159 and OUT_ERR=0; OUT_VALID high for exactly one cycle.
- Feed 00101, 11100 (DET=0), 00110, 01001 → BCD_WORD=16'h2F34, OUT_ERR=1, ERR_COUNT=1.
- Feed a legal pattern 10001 with DET=1 → nibble F, ERR_COUNT increments. Then feed 260 invalid words → ERR_COUNT=255 and does not wrap.
- Hold OUT_READY=0 for 10 cycles after a word completes → IN_READY=0 and BCD_WORD stable throughout. Raise OUT_READY → IN_READY=1 on the next cycle.
- Assert RST_N=0 after 2 of 4 digits → all outputs return to reset values. The next 4 digits form a fresh word with no residue.
- CLR_ERR pulsed in the same cycle as an invalid accept with ERR_COUNT=7 → ERR_COUNT=1.
